// File: rtl/uart_tx_fifo_if.sv
// Byte-write / serial-line bundle for uart_tx_fifo.
// The master side supplies DIN/WE and watches the status signals;
// the slave side (the transmitter) drives the line and the status signals.
interface uart_tx_fifo_if #(
  parameter int WDATA = 8,
  parameter int DEPTH = 4
);
  logic [WDATA-1:0]             DIN;
  logic                         WE;
  logic                         RDY;
  logic                         TXD;
  logic                         BUSY;
  logic [$clog2(DEPTH+1)-1:0]   LEVEL;
  logic                         OVF;

  modport master (output DIN, WE, input RDY, TXD, BUSY, LEVEL, OVF);
  modport slave  (input DIN, WE, output RDY, TXD, BUSY, LEVEL, OVF);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// Frames are START, WDATA bits LSB first, optional parity, WSTOP stop bits,
// every bit held for NTICKS = FCLK/BAUDS clock cycles. Queued bytes are sent
// back to back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int FCLK   = 12000000,
  parameter int BAUDS  = 115200,
  parameter int WDATA  = 8,
  parameter int WSTOP  = 1,
  parameter int PARITY = 0,
  parameter int DEPTH  = 4
) (
  input logic        CLK,
  input logic        RST,
  uart_tx_fifo_if.slave bus
);
  localparam int NTICKS = FCLK / BAUDS;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int TW     = $clog2(WSTOP * NTICKS + 1);
  localparam int BW     = $clog2(WDATA);
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(NTICKS - 1);
  localparam logic [TW-1:0] STOP_RELOAD = TW'(WSTOP * NTICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state, state_next;
  logic [WDATA-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              ovf;
  logic [WDATA-1:0]  shift, shift_next;
  logic [TW-1:0]     tick, tick_next;
  logic [BW-1:0]     bit_cnt, bit_next;
  logic              par_bit, par_next;
  logic              txd, txd_next;
  logic              rdy, push, pop, non_empty;
  logic [WDATA-1:0]  head;

  assign rdy       = (level != LW'(DEPTH));
  assign push      = bus.WE && rdy;
  assign non_empty = (level != '0);
  assign head      = mem[rd_ptr];

  assign bus.RDY   = rdy;
  assign bus.TXD   = txd;
  assign bus.BUSY  = (state != IDLE);
  assign bus.LEVEL = level;
  assign bus.OVF   = ovf;

  // FIFO storage: written on an accepted push, never cleared.
  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_ptr] <= bus.DIN;
  end

  // FIFO pointers and exact occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Sticky overflow flag: a write was attempted while the FIFO was full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              ovf <= 1'b0;
    else if (bus.WE && !rdy) ovf <= 1'b1;
  end

  // Transmitter state, bit timer, shift register and the registered line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      tick    <= BIT_RELOAD;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state   <= state_next;
      tick    <= tick_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      par_bit <= par_next;
      txd     <= txd_next;
    end
  end

  // Next-state logic: pops load the shift register, bit boundaries reload the timer.
  always_comb begin
    state_next = state;
    tick_next  = tick;
    bit_next   = bit_cnt;
    shift_next = shift;
    par_next   = par_bit;
    txd_next   = txd;
    pop        = 1'b0;
    if (state == IDLE) begin
      if (non_empty) begin
        pop        = 1'b1;
        shift_next = head;
        par_next   = (PARITY == 1) ? ~(^head) : (^head);
        txd_next   = 1'b0;
        tick_next  = BIT_RELOAD;
        state_next = START;
      end
    end else if (tick != '0) begin
      tick_next = tick - TW'(1);
    end else begin
      case (state)
        START: begin
          txd_next   = shift[0];
          shift_next = shift >> 1;
          bit_next   = '0;
          tick_next  = BIT_RELOAD;
          state_next = DATA;
        end
        DATA: begin
          if (bit_cnt == BW'(WDATA - 1)) begin
            if (PARITY != 0) begin
              txd_next   = par_bit;
              tick_next  = BIT_RELOAD;
              state_next = PAR;
            end else begin
              txd_next   = 1'b1;
              tick_next  = STOP_RELOAD;
              state_next = STOP;
            end
          end else begin
            txd_next   = shift[0];
            shift_next = shift >> 1;
            bit_next   = bit_cnt + BW'(1);
            tick_next  = BIT_RELOAD;
          end
        end
        PAR: begin
          txd_next   = 1'b1;
          tick_next  = STOP_RELOAD;
          state_next = STOP;
        end
        STOP: begin
          if (non_empty) begin
            pop        = 1'b1;
            shift_next = head;
            par_next   = (PARITY == 1) ? ~(^head) : (^head);
            txd_next   = 1'b0;
            tick_next  = BIT_RELOAD;
            state_next = START;
          end else begin
            txd_next   = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          txd_next   = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (even parity/1 stop, odd parity/2 stop,
// no parity/1 stop) share clock, reset and write stimulus; a queue-based frame
// model predicts TXD/BUSY/RDY/OVF/LEVEL of each one every cycle.
module tb_uart_tx_fifo;
  localparam int NT = 16;
  localparam int ND = 3;
  localparam int PAR_C [ND] = '{2, 1, 0};
  localparam int WST_C [ND] = '{1, 2, 1};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       we  = 1'b0;
  logic [7:0] din = 8'h00;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_tx_fifo_if #(.WDATA(8), .DEPTH(4)) bus0 ();
  uart_tx_fifo_if #(.WDATA(8), .DEPTH(4)) bus1 ();
  uart_tx_fifo_if #(.WDATA(8), .DEPTH(4)) bus2 ();
  assign bus0.WE = we;  assign bus0.DIN = din;
  assign bus1.WE = we;  assign bus1.DIN = din;
  assign bus2.WE = we;  assign bus2.DIN = din;

  uart_tx_fifo #(.FCLK(16), .BAUDS(1), .WDATA(8), .WSTOP(1), .PARITY(2), .DEPTH(4))
    dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  uart_tx_fifo #(.FCLK(16), .BAUDS(1), .WDATA(8), .WSTOP(2), .PARITY(1), .DEPTH(4))
    dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  uart_tx_fifo #(.FCLK(16), .BAUDS(1), .WDATA(8), .WSTOP(1), .PARITY(0), .DEPTH(4))
    dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  // Observed status per instance: {TXD, BUSY, RDY, OVF, LEVEL[2:0]}
  logic [6:0] obs [ND];
  assign obs[0] = {bus0.TXD, bus0.BUSY, bus0.RDY, bus0.OVF, bus0.LEVEL};
  assign obs[1] = {bus1.TXD, bus1.BUSY, bus1.RDY, bus1.OVF, bus1.LEVEL};
  assign obs[2] = {bus2.TXD, bus2.BUSY, bus2.RDY, bus2.OVF, bus2.LEVEL};

  // ---------------- reference model ----------------
  logic [7:0]  q0[$], q1[$], q2[$];
  bit          m_in  [ND];
  int          m_cyc [ND];
  logic [15:0] m_bits[ND];
  bit          m_ovf [ND];

  function automatic int qsize(int d);
    if (d == 0) return q0.size();
    if (d == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic void qpush(int d, logic [7:0] v);
    if (d == 0) q0.push_back(v);
    else if (d == 1) q1.push_back(v);
    else q2.push_back(v);
  endfunction

  function automatic logic [7:0] qpop(int d);
    if (d == 0) return q0.pop_front();
    if (d == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  function automatic int frame_len(int d);
    return (1 + 8 + ((PAR_C[d] != 0) ? 1 : 0) + WST_C[d]) * NT;
  endfunction

  // Bit k of the result is the line level during bit period k of the frame.
  function automatic logic [15:0] frame_bits(int d, logic [7:0] b);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    if (PAR_C[d] != 0) f[9] = (PAR_C[d] == 2) ? ^b : ~(^b);
    return f;
  endfunction

  function automatic logic [6:0] exp_vec(int d);
    int   sz;
    logic t;
    sz = qsize(d);
    t  = m_in[d] ? m_bits[d][m_cyc[d] / NT] : 1'b1;
    return {t, m_in[d], (sz < 4), m_ovf[d], 3'(sz)};
  endfunction

  always @(posedge CLK or posedge RST) begin
    int sz;
    bit do_pop;
    if (RST) begin
      q0.delete(); q1.delete(); q2.delete();
      for (int d = 0; d < ND; d++) begin
        m_in[d] = 1'b0; m_cyc[d] = 0; m_ovf[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        sz = qsize(d);
        if (we && sz == 4) m_ovf[d] = 1'b1;
        do_pop = (sz > 0) && (!m_in[d] || m_cyc[d] == frame_len(d) - 1);
        if (do_pop) begin
          m_bits[d] = frame_bits(d, qpop(d));
          m_in[d]   = 1'b1;
          m_cyc[d]  = 0;
        end else if (m_in[d]) begin
          if (m_cyc[d] == frame_len(d) - 1) m_in[d] = 1'b0;
          else m_cyc[d] = m_cyc[d] + 1;
        end
        if (we && sz < 4) qpush(d, din);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    we = 1'b1; din = 8'hC3;
    repeat (2) @(negedge CLK);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d] !== 7'b1010000) begin
        failures++;
        $display("FAIL reset_state dut%0d got=%b exp=%b", d, obs[d], 7'b1010000);
      end
    end
    we = 1'b0;
    RST = 1'b0;
  endtask

  task automatic test_single_frames();
    logic [7:0]  bytes [3] = '{8'h55, 8'h00, 8'hFF};
    int          busy_n [ND];
    logic [10:0] pat;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); we = 1'b1; din = bytes[k];
      @(negedge CLK); we = 1'b0;
      for (int d = 0; d < ND; d++) busy_n[d] = 0;
      pat = '0;
      for (int c = 0; c < 230; c++) begin
        for (int d = 0; d < ND; d++) begin
          checks++;
          if (obs[d] !== exp_vec(d)) begin
            failures++;
            if (failures <= 20) $display("FAIL frame_%h dut%0d cyc=%0d got=%b exp=%b", bytes[k], d, c, obs[d], exp_vec(d));
          end
          if (obs[d][5] === 1'b1) begin
            if (d == 0 && busy_n[0] % NT == 8) pat = {pat[9:0], obs[0][6]};
            busy_n[d]++;
          end
        end
        @(negedge CLK);
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (busy_n[d] != frame_len(d)) begin
          failures++;
          $display("FAIL busy_len_%h dut%0d got=%0d exp=%0d", bytes[k], d, busy_n[d], frame_len(d));
        end
      end
      if (k == 0) begin
        checks++;
        if (pat !== 11'b01010101001) begin
          failures++;
          $display("FAIL even_parity_55_pattern got=%b exp=%b", pat, 11'b01010101001);
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) begin
      we = 1'b1; din = 8'(i);
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          failures++;
          if (failures <= 20) $display("FAIL ovf_fill dut%0d i=%0d got=%b exp=%b", d, i, obs[d], exp_vec(d));
        end
      end
    end
    we = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d][4:0] !== 5'b01100) begin
        failures++;
        $display("FAIL ovf_status dut%0d got=%b exp=%b", d, obs[d][4:0], 5'b01100);
      end
    end
    for (int c = 0; c < 1010; c++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          failures++;
          if (failures <= 20) $display("FAIL ovf_drain dut%0d cyc=%0d got=%b exp=%b", d, c, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_same_edge();
    int waited = 0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; din = 8'($urandom);
      @(negedge CLK);
    end
    we = 1'b0;
    checks++;
    if (bus0.LEVEL !== 3'd2) begin
      failures++;
      $display("FAIL same_edge_prelevel got=%0d exp=2", bus0.LEVEL);
    end
    while (!(m_in[0] && m_cyc[0] == frame_len(0) - 1) && waited < 400) begin
      @(negedge CLK);
      waited++;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          failures++;
          if (failures <= 20) $display("FAIL same_edge_wait dut%0d got=%b exp=%b", d, obs[d], exp_vec(d));
        end
      end
    end
    checks++;
    if (waited >= 400) begin
      failures++;
      $display("FAIL same_edge_timeout got=%0d exp=<400", waited);
    end
    we = 1'b1; din = 8'hA5;
    @(negedge CLK);
    we = 1'b0;
    checks++;
    if (bus0.LEVEL !== 3'd2 || bus0.RDY !== 1'b1 || bus0.TXD !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_level got=%0d/%b/%b exp=2/1/0", bus0.LEVEL, bus0.RDY, bus0.TXD);
    end
    for (int c = 0; c < 800; c++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          failures++;
          if (failures <= 20) $display("FAIL same_edge_drain dut%0d cyc=%0d got=%b exp=%b", d, c, obs[d], exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int waited = 0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; din = 8'($urandom);
      @(negedge CLK);
    end
    we = 1'b0;
    while (!(m_in[0] && m_cyc[0] == 4 * NT + 3) && waited < 300) begin
      @(negedge CLK);
      waited++;
    end
    checks++;
    if (waited >= 300) begin
      failures++;
      $display("FAIL midreset_timeout got=%0d exp=<300", waited);
    end
    checks++;
    if (bus0.TXD === 1'b1 && bus0.LEVEL === 3'd2) begin
      failures++;
      $display("FAIL midreset_precondition got=txd%b/lvl%0d exp=data_bit_in_flight", bus0.TXD, bus0.LEVEL);
    end
    #2 RST = 1'b1; we = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d] !== 7'b1010000) begin
        failures++;
        $display("FAIL midreset_async dut%0d got=%b exp=%b", d, obs[d], 7'b1010000);
      end
    end
    @(negedge CLK);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (obs[d] !== 7'b1010000) begin
        failures++;
        $display("FAIL midreset_we_ignored dut%0d got=%b exp=%b", d, obs[d], 7'b1010000);
      end
    end
    we = 1'b0; RST = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== 7'b1010000) begin
          failures++;
          if (failures <= 20) $display("FAIL midreset_line_idle dut%0d cyc=%0d got=%b exp=%b", d, c, obs[d], 7'b1010000);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      we  = ($urandom_range(0, 59) == 0) || (c % 1000 < 8);
      din = 8'($urandom);
      @(negedge CLK);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (obs[d] !== exp_vec(d)) begin
          failures++;
          if (failures <= 20) $display("FAIL random dut%0d cyc=%0d got=%b exp=%b", d, c, obs[d], exp_vec(d));
        end
      end
    end
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frames();
    test_overflow();
    test_same_edge();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
